// File: rtl/pd_pkg.sv
// Shared types and status codes for the pattern-detect session controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pd_pkg;

  // Session FSM states
  typedef enum logic [1:0] {
    PD_IDLE  = 2'b00,
    PD_ARMED = 2'b01,
    PD_DONE  = 2'b10
  } pd_state_t;

  // Session end status codes reported on the status port
  localparam logic [1:0] PD_ST_NONE    = 2'b00;
  localparam logic [1:0] PD_ST_HIT     = 2'b01;
  localparam logic [1:0] PD_ST_TIMEOUT = 2'b10;
  localparam logic [1:0] PD_ST_ABORT   = 2'b11;

endpackage

// File: rtl/pd_match_core.sv
// Serial shift register with fill tracking and a compare against a runtime pattern.
// Latency: match is combinational on the current bit (history registered, newest bit live).
// Backpressure: none; shifts only on x_valid, holds otherwise.
module pd_match_core #(
  parameter int unsigned SEQ_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               x_i,
  input  logic               x_valid,
  input  logic [SEQ_LEN-1:0] pat,
  output logic               match
);

  localparam int unsigned FILL_W = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_PRE  = FILL_W'(SEQ_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  // Only the SEQ_LEN-1 most recent bits need storage; the newest comes from x_i.
  logic [SEQ_LEN-2:0] sr_q, sr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [SEQ_LEN-1:0] window;

  assign window = {sr_q, x_i};

  // A match needs SEQ_LEN valid bits: SEQ_LEN-1 already stored plus the live one.
  assign match = x_valid & ~clr & (fill_q >= FILL_PRE) & (window == pat);

  // Next-state for history and fill level; clear wins over shifting
  always_comb begin
    sr_d   = sr_q;
    fill_d = fill_q;
    if (clr) begin
      sr_d   = '0;
      fill_d = '0;
    end else if (x_valid) begin
      sr_d = window[SEQ_LEN-2:0];
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_ONE;
      end
    end
  end

  // History and fill registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pd_session_ctrl.sv
// Pattern-detect session sequencer: config capture, arm/abort, match and window counting.
// Latency: det_o/match_cnt update one cycle after the matching bit; done pulses the cycle after the end event.
// Backpressure: cfg_ready is high only in IDLE; x_i is never stalled, gaps are expressed by x_valid=0.
module pd_session_ctrl
  import pd_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WIN_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [SEQ_LEN-1:0] cfg_pat,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic               start,
  input  logic               abort,
  input  logic               x_i,
  input  logic               x_valid,
  output logic               busy,
  output logic               det_o,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic [1:0]         status
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  pd_state_t          state_q, state_d;
  logic [SEQ_LEN-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [WIN_W-1:0]   window_q, window_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic               det_q, det_d;
  logic               done_q, done_d;
  logic [1:0]         status_q, status_d;

  logic               idle, armed;
  logic               cfg_acc, start_acc;
  logic               bit_vld, match;
  logic               abort_evt, hit_evt, to_evt, end_evt, count_match;
  logic [CNT_W-1:0]   cnt_inc;
  logic [WIN_W-1:0]   win_inc;

  assign idle  = (state_q == PD_IDLE);
  assign armed = (state_q == PD_ARMED);

  assign cfg_ready = idle;
  assign busy      = ~idle;
  assign det_o     = det_q;
  assign match_cnt = match_cnt_q;
  assign done      = done_q;
  assign status    = status_q;

  assign cfg_acc   = cfg_valid & idle;
  assign start_acc = start & idle;
  assign bit_vld   = x_valid & armed;

  // The core is only read in ARMED, by which point a same-cycle cfg+start
  // has already landed in pat_q, so the fresh pattern is used without a mux.
  pd_match_core #(
    .SEQ_LEN (SEQ_LEN)
  ) u_match_core (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_acc),
    .x_i     (x_i),
    .x_valid (bit_vld),
    .pat     (pat_q),
    .match   (match)
  );

  assign cnt_inc = match_cnt_q + CNT_ONE;
  assign win_inc = win_cnt_q + WIN_ONE;

  // A zero target finishes immediately; otherwise the session ends on the
  // match that brings the count up to target, so match_cnt never wraps.
  assign abort_evt   = armed & abort;
  assign hit_evt     = armed & ((target_q == '0) | (match & (cnt_inc == target_q)));
  assign to_evt      = bit_vld & (window_q != '0) & (win_inc == window_q);
  assign end_evt     = abort_evt | hit_evt | to_evt;
  assign count_match = match & ~abort_evt & (target_q != '0);

  // Next-state: config capture, FSM, counters and registered outputs
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    target_d    = target_q;
    window_d    = window_q;
    win_cnt_d   = win_cnt_q;
    match_cnt_d = match_cnt_q;
    status_d    = status_q;
    det_d       = 1'b0;
    done_d      = 1'b0;

    if (cfg_acc) begin
      pat_d    = cfg_pat;
      target_d = cfg_target;
      window_d = cfg_window;
    end

    case (state_q)
      PD_IDLE: begin
        if (start) begin
          state_d     = PD_ARMED;
          win_cnt_d   = '0;
          match_cnt_d = '0;
          status_d    = PD_ST_NONE;
        end
      end
      PD_ARMED: begin
        if (bit_vld) begin
          win_cnt_d = win_inc;
        end
        if (count_match) begin
          det_d       = 1'b1;
          match_cnt_d = cnt_inc;
        end
        if (abort_evt) begin
          status_d = PD_ST_ABORT;
        end else if (hit_evt) begin
          status_d = PD_ST_HIT;
        end else if (to_evt) begin
          status_d = PD_ST_TIMEOUT;
        end
        if (end_evt) begin
          state_d = PD_DONE;
          done_d  = 1'b1;
        end
      end
      PD_DONE: begin
        state_d = PD_IDLE;
      end
      default: begin
        state_d = PD_IDLE;
      end
    endcase
  end

  // State, config and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PD_IDLE;
      pat_q       <= '0;
      target_q    <= '0;
      window_q    <= '0;
      win_cnt_q   <= '0;
      match_cnt_q <= '0;
      det_q       <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= PD_ST_NONE;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      target_q    <= target_d;
      window_q    <= window_d;
      win_cnt_q   <= win_cnt_d;
      match_cnt_q <= match_cnt_d;
      det_q       <= det_d;
      done_q      <= done_d;
      status_q    <= status_d;
    end
  end

endmodule

// File: tb/tb_pd_session_ctrl.sv
// Directed bench for pd_session_ctrl with hand-computed expectations.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_pd_session_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_pat;
  logic [7:0]  cfg_target;
  logic [15:0] cfg_window;
  logic        start;
  logic        abort;
  logic        x_i;
  logic        x_valid;
  logic        busy;
  logic        det_o;
  logic [7:0]  match_cnt;
  logic        done;
  logic [1:0]  status;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pd_session_ctrl #(
    .SEQ_LEN (8),
    .CNT_W   (8),
    .WIN_W   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pat    (cfg_pat),
    .cfg_target (cfg_target),
    .cfg_window (cfg_window),
    .start      (start),
    .abort      (abort),
    .x_i        (x_i),
    .x_valid    (x_valid),
    .busy       (busy),
    .det_o      (det_o),
    .match_cnt  (match_cnt),
    .done       (done),
    .status     (status)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one config beat, optionally with start in the same cycle.
  task automatic do_cfg(input logic [7:0] pat, input logic [7:0] tgt,
                        input logic [15:0] win, input logic with_start);
    cfg_valid  = 1'b1;
    cfg_pat    = pat;
    cfg_target = tgt;
    cfg_window = win;
    start      = with_start;
    step();
    cfg_valid  = 1'b0;
    start      = 1'b0;
  endtask

  // Send n bits MSB first; det_mask[i] is the expected det_o after bit bits[i].
  // gap_pct > 0 inserts up to 3 idle cycles before each bit.
  task automatic send_stream(input logic [31:0] bits, input int n,
                             input logic [31:0] det_mask, input int gap_pct,
                             input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      for (int g = 0; g < 3 && gap_pct > 0 && $urandom_range(99) < gap_pct; g++) begin
        x_valid = 1'b0;
        step();
        check({tag, " gap det"}, det_o, 0);
      end
      x_i     = bits[i];
      x_valid = 1'b1;
      step();
      check($sformatf("%s det bit%0d", tag, n - i), det_o, det_mask[i]);
    end
    x_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_pat    = '0;
    cfg_target = '0;
    cfg_window = '0;
    start      = 1'b0;
    abort      = 1'b0;
    x_i        = 1'b0;
    x_valid    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst cfg_ready", cfg_ready, 1);
    check("rst busy", busy, 0);
    check("rst det", det_o, 0);
    check("rst done", done, 0);
    check("rst status", status, 0);
    check("rst match_cnt", match_cnt, 0);
    reset = 1'b0;
    step();

    // Single match, target 1, no window
    do_cfg(8'hAC, 8'd1, 16'd0, 1'b0);
    check("t1 cfg_ready idle", cfg_ready, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1 busy armed", busy, 1);
    check("t1 cfg_ready armed", cfg_ready, 0);
    send_stream(32'hAC, 8, 32'h1, 0, "t1");
    check("t1 done", done, 1);
    check("t1 status", status, 1);
    check("t1 match_cnt", match_cnt, 1);
    check("t1 busy in done", busy, 1);
    step();
    check("t1 done drop", done, 0);
    check("t1 busy idle", busy, 0);
    check("t1 det drop", det_o, 0);
    check("t1 status hold", status, 1);
    check("t1 match_cnt hold", match_cnt, 1);

    // Overlapping matches, target 3
    do_cfg(8'hAA, 8'd3, 16'd0, 1'b1);
    check("t2 status cleared", status, 0);
    check("t2 match_cnt cleared", match_cnt, 0);
    send_stream(32'h2AA, 10, 32'h5, 0, "t2");
    check("t2 match_cnt 2", match_cnt, 2);
    check("t2 not done", done, 0);
    send_stream(32'h2, 2, 32'h1, 0, "t2b");
    check("t2 done", done, 1);
    check("t2 status", status, 1);
    check("t2 match_cnt 3", match_cnt, 3);
    step();

    // Window timeout on bit 20
    do_cfg(8'hFF, 8'd2, 16'd20, 1'b1);
    send_stream(32'h0, 19, 32'h0, 0, "t3");
    check("t3 no done at 19", done, 0);
    check("t3 busy at 19", busy, 1);
    send_stream(32'h0, 1, 32'h0, 0, "t3 last");
    check("t3 done", done, 1);
    check("t3 status timeout", status, 2);
    check("t3 match_cnt", match_cnt, 0);
    step();
    check("t3 idle", busy, 0);

    // Hit and timeout on the same bit: hit wins
    do_cfg(8'hFF, 8'd1, 16'd20, 1'b1);
    send_stream(32'h000FF, 20, 32'h1, 0, "t3b");
    check("t3b done", done, 1);
    check("t3b status hit", status, 1);
    check("t3b match_cnt", match_cnt, 1);
    step();

    // Abort outside ARMED is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4 idle abort status", status, 1);
    check("t4 idle abort busy", busy, 0);
    check("t4 idle abort done", done, 0);

    // Start while ARMED ignored; abort on a matching bit
    do_cfg(8'hAC, 8'd2, 16'd0, 1'b1);
    send_stream(32'hAC, 8, 32'h1, 0, "t4");
    check("t4 match_cnt 1", match_cnt, 1);
    check("t4 not done", done, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4 restart ignored cnt", match_cnt, 1);
    check("t4 restart ignored busy", busy, 1);
    check("t4 restart ignored status", status, 0);
    send_stream(32'h56, 7, 32'h0, 0, "t4b");
    x_i     = 1'b0;
    x_valid = 1'b1;
    abort   = 1'b1;
    step();
    x_valid = 1'b0;
    abort   = 1'b0;
    check("t4 abort det", det_o, 0);
    check("t4 abort match_cnt", match_cnt, 1);
    check("t4 abort done", done, 1);
    check("t4 abort status", status, 3);
    step();

    // Gapless and gapped streams give the same count
    do_cfg(8'hAC, 8'd3, 16'd0, 1'b1);
    send_stream(32'hACAC, 16, 32'h0101, 0, "t5");
    check("t5 match_cnt", match_cnt, 2);
    check("t5 not done", done, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5 abort status", status, 3);
    step();
    do_cfg(8'hAC, 8'd3, 16'd0, 1'b1);
    send_stream(32'hACAC, 16, 32'h0101, 50, "t5g");
    check("t5g match_cnt", match_cnt, 2);
    check("t5g not done", done, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5g abort done", done, 1);
    step();

    // Zero target ends right away
    do_cfg(8'hAC, 8'd0, 16'd0, 1'b1);
    check("t5z busy", busy, 1);
    check("t5z no done yet", done, 0);
    step();
    check("t5z done", done, 1);
    check("t5z status", status, 1);
    check("t5z match_cnt", match_cnt, 0);
    step();
    check("t5z idle", busy, 0);

    // Asynchronous reset mid-session
    do_cfg(8'hAC, 8'd2, 16'd0, 1'b1);
    send_stream(32'hAC, 8, 32'h1, 0, "t6");
    check("t6 match_cnt pre", match_cnt, 1);
    #2 reset = 1'b1;
    #1;
    check("t6 rst busy", busy, 0);
    check("t6 rst cfg_ready", cfg_ready, 1);
    check("t6 rst match_cnt", match_cnt, 0);
    check("t6 rst det", det_o, 0);
    check("t6 rst status", status, 0);
    check("t6 rst done", done, 0);
    step();
    check("t6 rst no done", done, 0);
    reset = 1'b0;
    step();

    // Config and start together use the new pattern
    do_cfg(8'h35, 8'd1, 16'd0, 1'b1);
    send_stream(32'h35, 8, 32'h1, 0, "t6b");
    check("t6b done", done, 1);
    check("t6b status", status, 1);
    check("t6b match_cnt", match_cnt, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
